// File: rtl/present_decryptor_top.sv
// Iterative PRESENT-80 decryption core: expands the key to round 32 once, then 31 inverse rounds.
// Optional build macro PRESENT_DEC_ZEROIZE_EN hides data_o unless a finished plaintext is held.
module present_decryptor_top (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [79:0] data_i,
  input  logic        key_load,
  input  logic        data_load,
  output logic [63:0] data_o,
  output logic        ready_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {StNoKey, StExpand, StIdle, StDecrypt} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [79:0] k32_q, k32_d;
  logic [4:0]  rc_q, rc_d;
  logic        valid_q, valid_d;
  logic [79:0] key_up, key_dn;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  // Undo key_fwd: counter xor and S-box touch disjoint bits, then rotate right by 61.
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = k;
    r[19:15] = r[19:15] ^ rc;
    r[79:76] = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  function automatic logic [63:0] inv_round(input logic [63:0] s);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 63; i++) begin
      p[6'(i)] = s[6'((16 * i) % 63)];
    end
    p[63] = s[63];
    for (int n = 0; n < 16; n++) begin
      p[6'(4 * n) +: 4] = inv_sbox(p[6'(4 * n) +: 4]);
    end
    return p;
  endfunction

  assign key_up = key_fwd(key_q, rc_q);
  assign key_dn = key_inv(key_q, rc_q);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    k32_d   = k32_q;
    rc_d    = rc_q;
    valid_d = valid_q;
    unique case (fsm_q)
      StNoKey, StIdle: begin
        // key_load takes priority; data_load only counts once a schedule exists.
        if (key_load) begin
          key_d   = data_i;
          rc_d    = 5'd1;
          valid_d = 1'b0;
          fsm_d   = StExpand;
        end else if (data_load && (fsm_q == StIdle)) begin
          state_d = data_i[63:0] ^ k32_q[79:16];
          key_d   = k32_q;
          rc_d    = 5'd31;
          valid_d = 1'b0;
          fsm_d   = StDecrypt;
        end
      end
      StExpand: begin
        key_d = key_up;
        rc_d  = rc_q + 5'd1;
        if (rc_q == 5'd31) begin
          k32_d = key_up;
          fsm_d = StIdle;
        end
      end
      StDecrypt: begin
        key_d   = key_dn;
        state_d = inv_round(state_q) ^ key_dn[79:16];
        rc_d    = rc_q - 5'd1;
        if (rc_q == 5'd1) begin
          valid_d = 1'b1;
          fsm_d   = StIdle;
        end
      end
      default: fsm_d = StNoKey;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= StNoKey;
      state_q <= '0;
      key_q   <= '0;
      k32_q   <= '0;
      rc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      k32_q   <= k32_d;
      rc_q    <= rc_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = (fsm_q == StIdle);
  assign valid_o = valid_q;

`ifdef PRESENT_DEC_ZEROIZE_EN
  assign data_o = valid_q ? state_q : 64'h0;
`else
  assign data_o = state_q;
`endif

endmodule
